// File: rtl/spi_slave_responder.sv
// SPI slave (responder): oversampled pins, full-duplex MSB-first words, valid/ready TX and RX sides.
// Optional RX FIFO storage is enabled by defining SPI_SLAVE_RX_FIFO_EN.
module spi_slave_responder #(
   parameter int                DATA_W        = 8,
   parameter logic [DATA_W-1:0] TX_IDLE       = 8'hFF,
   parameter int                RX_FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              sclk,
   input  logic              ss_n,
   input  logic              mosi_somi,
   output logic              miso_simo,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              tx_underrun,
   output logic              rx_overrun
);

   localparam int            CW       = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

   if ((RX_FIFO_DEPTH < 2) || ((RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("RX_FIFO_DEPTH must be a power of two, at least 2");
   end

   logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
   logic ss_meta_r, ss_sync_r, ss_prev_r;
   logic mosi_meta_r, mosi_sync_r;

   logic              cpol_r, cpha_r, busy_r, oe_r, miso_r;
   logic              first_r, word_done_r, underrun_r, overrun_r, tx_ready_r;
   logic [CW-1:0]     bit_cnt_r;
   logic [DATA_W-1:0] tx_shift_r, tx_buf_r;
   logic [DATA_W-2:0] rx_shift_r;
   logic [DATA_W-1:0] rx_data_s;
   logic              rx_valid_s;

   logic              sclk_rise_s, sclk_fall_s, lead_s, trail_s;
   logic              frame_start_s, frame_end_s, active_s;
   logic              sample_s, shift_s, complete_s, load_s, pop_s;
   logic [DATA_W-1:0] rx_word_s, next_word_s;

   // Two-flop synchronizers; ss_n resets low so a select held low across reset is not a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_meta_r <= 1'b0;
         sclk_sync_r <= 1'b0;
         sclk_prev_r <= 1'b0;
         ss_meta_r   <= 1'b0;
         ss_sync_r   <= 1'b0;
         ss_prev_r   <= 1'b0;
         mosi_meta_r <= 1'b0;
         mosi_sync_r <= 1'b0;
      end else begin
         sclk_meta_r <= sclk;
         sclk_sync_r <= sclk_meta_r;
         sclk_prev_r <= sclk_sync_r;
         ss_meta_r   <= ss_n;
         ss_sync_r   <= ss_meta_r;
         ss_prev_r   <= ss_sync_r;
         mosi_meta_r <= mosi_somi;
         mosi_sync_r <= mosi_meta_r;
      end
   end

   assign sclk_rise_s   = sclk_sync_r & ~sclk_prev_r;
   assign sclk_fall_s   = ~sclk_sync_r & sclk_prev_r;
   assign lead_s        = cpol_r ? sclk_fall_s : sclk_rise_s;
   assign trail_s       = cpol_r ? sclk_rise_s : sclk_fall_s;
   assign frame_start_s = ~busy_r & ss_prev_r & ~ss_sync_r;
   assign frame_end_s   = busy_r & ss_sync_r;
   assign active_s      = busy_r & ~frame_end_s;
   assign sample_s      = active_s & (cpha_r ? trail_s : lead_s);
   assign shift_s       = active_s & (cpha_r ? lead_s : trail_s);
   assign complete_s    = sample_s & (bit_cnt_r == LAST_BIT);
   assign rx_word_s     = {rx_shift_r, mosi_sync_r};
   assign next_word_s   = tx_ready_r ? TX_IDLE : tx_buf_r;
   assign load_s        = frame_start_s | (shift_s & word_done_r);

   // Frame control, bit counting, TX buffer and both shift registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpol_r      <= 1'b0;
         cpha_r      <= 1'b0;
         busy_r      <= 1'b0;
         oe_r        <= 1'b0;
         miso_r      <= 1'b0;
         first_r     <= 1'b0;
         word_done_r <= 1'b0;
         underrun_r  <= 1'b0;
         tx_ready_r  <= 1'b1;
         bit_cnt_r   <= {CW{1'b0}};
         tx_shift_r  <= {DATA_W{1'b0}};
         tx_buf_r    <= {DATA_W{1'b0}};
         rx_shift_r  <= {(DATA_W-1){1'b0}};
      end else begin
         underrun_r <= 1'b0;
         if (tx_valid && tx_ready_r) begin
            tx_buf_r   <= tx_data;
            tx_ready_r <= 1'b0;
         end
         if (frame_start_s) begin
            cpol_r      <= cpol;
            cpha_r      <= cpha;
            busy_r      <= 1'b1;
            oe_r        <= 1'b1;
            bit_cnt_r   <= {CW{1'b0}};
            rx_shift_r  <= {(DATA_W-1){1'b0}};
            word_done_r <= 1'b0;
            first_r     <= cpha;
            tx_shift_r  <= next_word_s;
            // With CPHA=1 the MSB waits for the first leading edge.
            miso_r      <= cpha ? 1'b0 : next_word_s[DATA_W-1];
         end else if (frame_end_s) begin
            busy_r      <= 1'b0;
            oe_r        <= 1'b0;
            miso_r      <= 1'b0;
            bit_cnt_r   <= {CW{1'b0}};
            rx_shift_r  <= {(DATA_W-1){1'b0}};
            word_done_r <= 1'b0;
            first_r     <= 1'b0;
         end else begin
            if (sample_s) begin
               rx_shift_r <= rx_word_s[DATA_W-2:0];
               if (bit_cnt_r == LAST_BIT) begin
                  bit_cnt_r   <= {CW{1'b0}};
                  word_done_r <= 1'b1;
               end else begin
                  bit_cnt_r <= bit_cnt_r + CW'(1);
               end
            end
            if (shift_s) begin
               if (word_done_r) begin
                  tx_shift_r  <= next_word_s;
                  miso_r      <= next_word_s[DATA_W-1];
                  word_done_r <= 1'b0;
               end else if (first_r) begin
                  miso_r  <= tx_shift_r[DATA_W-1];
                  first_r <= 1'b0;
               end else begin
                  tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                  miso_r     <= tx_shift_r[DATA_W-2];
               end
            end
         end
         if (load_s) begin
            if (!tx_ready_r) begin
               tx_ready_r <= 1'b1;
            end else begin
               underrun_r <= 1'b1;
            end
         end
      end
   end

`ifdef SPI_SLAVE_RX_FIFO_EN
   localparam int PW = $clog2(RX_FIFO_DEPTH);

   logic [DATA_W-1:0] fifo_mem_r [RX_FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [PW:0]       count_r;
   logic              full_s, push_s;

   assign rx_valid_s = (count_r != (PW+1)'(0));
   assign rx_data_s  = fifo_mem_r[rd_ptr_r];
   assign full_s     = (count_r == (PW+1)'(RX_FIFO_DEPTH));
   assign pop_s      = rx_valid_s & rx_ready;
   assign push_s     = complete_s & (~full_s | pop_s);

   // First-word-fall-through RX FIFO; a pop in the completion cycle frees room for the new word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
            fifo_mem_r[i] <= {DATA_W{1'b0}};
         end
         wr_ptr_r  <= {PW{1'b0}};
         rd_ptr_r  <= {PW{1'b0}};
         count_r   <= {(PW+1){1'b0}};
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= complete_s & full_s & ~pop_s;
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= rx_word_s;
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end
`else
   logic [DATA_W-1:0] rx_hold_r;
   logic              rx_hold_valid_r;

   assign rx_valid_s = rx_hold_valid_r;
   assign rx_data_s  = rx_hold_r;
   assign pop_s      = rx_hold_valid_r & rx_ready;

   // Single RX holding register; a word completing onto an unread one is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_hold_r       <= {DATA_W{1'b0}};
         rx_hold_valid_r <= 1'b0;
         overrun_r       <= 1'b0;
      end else begin
         overrun_r <= 1'b0;
         if (complete_s) begin
            if (rx_hold_valid_r && !rx_ready) begin
               overrun_r <= 1'b1;
            end else begin
               rx_hold_r       <= rx_word_s;
               rx_hold_valid_r <= 1'b1;
            end
         end else if (pop_s) begin
            rx_hold_valid_r <= 1'b0;
         end
      end
   end
`endif

   assign miso_simo   = miso_r;
   assign miso_oe     = oe_r;
   assign tx_ready    = tx_ready_r;
   assign rx_data     = rx_data_s;
   assign rx_valid    = rx_valid_s;
   assign busy        = busy_r;
   assign tx_underrun = underrun_r;
   assign rx_overrun  = overrun_r;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed self-checking bench for spi_slave_responder: a behavioural SPI master drives the pins.
module tb_spi_slave_responder;

   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpol, cpha, sclk, ss_n, mosi_somi;
   logic       miso_simo, miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic       busy, tx_underrun, rx_overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int und_cnt = 0;
   int ovr_cnt = 0;

   logic [7:0] m_out [4];
   logic [7:0] m_in  [4];

   spi_slave_responder dut (
      .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
      .mosi_somi(mosi_somi), .miso_simo(miso_simo), .miso_oe(miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_underrun === 1'b1) und_cnt++;
      if (rx_overrun === 1'b1) ovr_cnt++;
   end

   // One SPI frame of nbits; optionally raises rx_ready exactly in the final completion cycle.
   task automatic spi_frame(input logic p, input logic h, input int nbits,
                            input logic coincide, input logic [7:0] head);
      cpol = p; cpha = h; sclk = p;
      repeat (4) @(negedge clk);
      ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         int w, b;
         w = i / 8;
         b = 7 - (i % 8);
         if (!h) begin
            mosi_somi = m_out[w][b];
            repeat (HALF) @(negedge clk);
            m_in[w][b] = miso_simo;
            sclk = ~p;
            repeat (HALF) @(negedge clk);
            if (i != nbits - 1) sclk = p;
         end else begin
            sclk = ~p;
            mosi_somi = m_out[w][b];
            repeat (HALF) @(negedge clk);
            m_in[w][b] = miso_simo;
            sclk = p;
            if (coincide && (i == nbits - 1)) begin
               repeat (2) @(negedge clk);
               n_cmp++;
               if ({rx_valid, rx_data} !== {1'b1, head}) begin
                  n_bad++;
                  $display("FAIL coincide_head: got valid=%b data=%h, want valid=1 data=%h", rx_valid, rx_data, head);
               end
               rx_ready = 1'b1;
               @(negedge clk);
               rx_ready = 1'b0;
               repeat (HALF - 3) @(negedge clk);
            end else begin
               repeat (HALF) @(negedge clk);
            end
         end
      end
      ss_n = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = p;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic tx_preload(input logic [7:0] d);
      tx_data = d; tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic rx_drain();
      for (int k = 0; k < 8; k++) begin
         if (rx_valid) begin
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            @(negedge clk);
         end
      end
      n_cmp++;
      if (rx_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rx_drain: rx_valid=%b, want 0", rx_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi_somi = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      for (int r = 0; r < 2; r++) begin
         n_cmp++;
         if ({miso_simo, miso_oe, tx_ready, rx_valid, busy, tx_underrun, rx_overrun} !== 7'b0010000) begin
            n_bad++;
            $display("FAIL reset_flags[%0d]: got %b, want 0010000", r,
                     {miso_simo, miso_oe, tx_ready, rx_valid, busy, tx_underrun, rx_overrun});
         end
         n_cmp++;
         if (rx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rx_data[%0d]: got %h, want 00", r, rx_data);
         end
         rst = 1'b0;
         repeat (6) @(negedge clk);
      end
   endtask

   task automatic test_mode0();
      int u0;
      tx_preload(8'hA5);
      n_cmp++;
      if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL m0_tx_ready_full: got %b, want 0", tx_ready); end
      u0 = und_cnt;
      m_out[0] = 8'h3C;
      spi_frame(1'b0, 1'b0, 8, 1'b0, 8'h00);
      n_cmp++;
      if (m_in[0] !== 8'hA5) begin n_bad++; $display("FAIL m0_miso_word: got %h, want a5", m_in[0]); end
      n_cmp++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h3C}) begin
         n_bad++; $display("FAIL m0_rx: got valid=%b data=%h, want valid=1 data=3c", rx_valid, rx_data);
      end
      n_cmp++;
      if (und_cnt - u0 !== 0) begin n_bad++; $display("FAIL m0_underrun: got %0d pulses, want 0", und_cnt - u0); end
      n_cmp++;
      if ({tx_ready, busy, miso_oe} !== 3'b100) begin
         n_bad++; $display("FAIL m0_idle_flags: got %b, want 100", {tx_ready, busy, miso_oe});
      end
      rx_drain();
   endtask

   task automatic test_mode3_two_words();
      int u0, o0;
      tx_preload(8'hC3);
      u0 = und_cnt; o0 = ovr_cnt;
      m_out[0] = 8'h12; m_out[1] = 8'h34;
      spi_frame(1'b1, 1'b1, 16, 1'b0, 8'h00);
      n_cmp++;
      if ({m_in[0], m_in[1]} !== 16'hC3FF) begin
         n_bad++; $display("FAIL m3_miso_words: got %h %h, want c3 ff", m_in[0], m_in[1]);
      end
      n_cmp++;
      if (und_cnt - u0 !== 1) begin n_bad++; $display("FAIL m3_underrun: got %0d pulses, want 1", und_cnt - u0); end
      n_cmp++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h12}) begin
         n_bad++; $display("FAIL m3_rx_head: got valid=%b data=%h, want valid=1 data=12", rx_valid, rx_data);
      end
`ifdef SPI_SLAVE_RX_FIFO_EN
      n_cmp++;
      if (ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL m3_overrun: got %0d pulses, want 0", ovr_cnt - o0); end
`else
      n_cmp++;
      if (ovr_cnt - o0 !== 1) begin n_bad++; $display("FAIL m3_overrun: got %0d pulses, want 1", ovr_cnt - o0); end
`endif
      rx_drain();
   endtask

   task automatic test_abort();
      m_out[0] = 8'hF0;
      spi_frame(1'b0, 1'b1, 5, 1'b0, 8'h00);
      n_cmp++;
      if ({rx_valid, miso_oe, busy} !== 3'b000) begin
         n_bad++; $display("FAIL abort_flags: got %b, want 000", {rx_valid, miso_oe, busy});
      end
      m_out[0] = 8'h81;
      spi_frame(1'b0, 1'b1, 8, 1'b0, 8'h00);
      n_cmp++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h81}) begin
         n_bad++; $display("FAIL abort_next_rx: got valid=%b data=%h, want valid=1 data=81", rx_valid, rx_data);
      end
      rx_drain();
   endtask

   task automatic test_overrun();
      int u0, o0;
      u0 = und_cnt; o0 = ovr_cnt;
      m_out[0] = 8'h01; m_out[1] = 8'h02; m_out[2] = 8'h03;
      spi_frame(1'b1, 1'b0, 24, 1'b0, 8'h00);
      n_cmp++;
      if ({m_in[0], m_in[1], m_in[2]} !== 24'hFFFFFF) begin
         n_bad++; $display("FAIL ovr_idle_words: got %h %h %h, want ff ff ff", m_in[0], m_in[1], m_in[2]);
      end
      n_cmp++;
      if (und_cnt - u0 !== 3) begin n_bad++; $display("FAIL ovr_underrun: got %0d pulses, want 3", und_cnt - u0); end
`ifdef SPI_SLAVE_RX_FIFO_EN
      n_cmp++;
      if (ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL ovr_count: got %0d pulses, want 0", ovr_cnt - o0); end
      for (int k = 1; k <= 3; k++) begin
         n_cmp++;
         if ({rx_valid, rx_data} !== {1'b1, 8'(k)}) begin
            n_bad++; $display("FAIL ovr_pop[%0d]: got valid=%b data=%h, want valid=1 data=%h", k, rx_valid, rx_data, 8'(k));
         end
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
      end
`else
      n_cmp++;
      if (ovr_cnt - o0 !== 2) begin n_bad++; $display("FAIL ovr_count: got %0d pulses, want 2", ovr_cnt - o0); end
      n_cmp++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h01}) begin
         n_bad++; $display("FAIL ovr_rx_kept: got valid=%b data=%h, want valid=1 data=01", rx_valid, rx_data);
      end
`endif
      rx_drain();
   endtask

   task automatic test_back_to_back();
      int o0;
      o0 = ovr_cnt;
      m_out[0] = 8'h5A;
      spi_frame(1'b0, 1'b1, 8, 1'b0, 8'h00);
      m_out[0] = 8'h6B;
      spi_frame(1'b0, 1'b1, 8, 1'b1, 8'h5A);
      n_cmp++;
      if ({rx_valid, rx_data} !== {1'b1, 8'h6B}) begin
         n_bad++; $display("FAIL b2b_second: got valid=%b data=%h, want valid=1 data=6b", rx_valid, rx_data);
      end
      n_cmp++;
      if (ovr_cnt - o0 !== 0) begin n_bad++; $display("FAIL b2b_overrun: got %0d pulses, want 0", ovr_cnt - o0); end
      rx_drain();
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3_two_words();
      test_abort();
      test_overrun();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
- SPI slave (responder) that answers the MCU's SPI master pins (`sclk`, `ss_x`, `mosi_somi`, `miso_simo`).
- Used as the on-chip loopback target for SPI bring-up and as the SPI target block in the companion peripheral chip.
- Oversamples the SPI pins in the `clk` domain and shifts full-duplex words.
- Presents received words, and accepts words to transmit, over valid/ready handshakes.

Parameters:
- `DATA_W`, 8, bits per SPI word.
- `TX_IDLE`, 8'hFF, word shifted out when no TX word is buffered at word start.
- `RX_FIFO_DEPTH`, 4, RX FIFO entries; used only with `SPI_SLAVE_RX_FIFO_EN`, power of two.

Ports:
- `clk` in 1 system clock; must be at least 6x the `sclk` frequency.
- `rst` in 1 asynchronous active-high reset.
- `cpol` in 1 clock polarity; captured at frame start.
- `cpha` in 1 clock phase; captured at frame start.
- `sclk` in 1 SPI clock from the master, asynchronous.
- `ss_n` in 1 slave select, active-low, asynchronous.
- `mosi_somi` in 1 serial data from the master.
- `miso_simo` out 1 serial data to the master.
- `miso_oe` out 1 tristate enable for `miso_simo`.
- `tx_data` in `DATA_W` word to send.
- `tx_valid` in 1 TX word offered.
- `tx_ready` out 1 TX holding buffer empty.
- `rx_data` out `DATA_W` received word.
- `rx_valid` out 1 RX word available.
- `rx_ready` in 1 consumer accepts `rx_data`.
- `busy` out 1 frame active (synchronized `ss_n` low).
- `tx_underrun` out 1 one-cycle pulse: `TX_IDLE` was loaded.
- `rx_overrun` out 1 one-cycle pulse: a completed word was dropped.

Behaviour:
- **Clock and reset**
  - One clock (`clk`); reset is asynchronous and active-high (`rst`).
  - Reset values: `miso_simo`=0, `miso_oe`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `busy`=0, pulses=0.
  - Reset clears `bit_cnt`, both shift registers, the TX buffer and the RX storage.
- **Synchronization**
  - `sclk`, `ss_n` and `mosi_somi` each pass through a 2-FF synchronizer.
  - Edge detection compares synchronized `sclk` against its previous value.
  - Latency from an SPI edge to the internal event is 3 `clk` cycles.
- **Frame start** (synchronized `ss_n` falls)
  - Capture `cpol`/`cpha`; set `busy`=1 and `miso_oe`=1; clear `bit_cnt`.
  - Load the TX shift register.
- **Edge roles**
  - Leading edge = `sclk` leaving the `cpol` level; trailing edge = `sclk` returning to it.
  - CPHA=0: sample `mosi_somi` on the leading edge; shift out on the trailing edge. The first bit is driven at frame start.
  - CPHA=1: shift out on the leading edge; sample on the trailing edge.
  - Bits are MSB first.
- **TX load at each word start**
  - Word start = frame start or the shift-out event that follows the `DATA_W`th sample.
  - CPHA=1 exception: the first word of a frame loads at frame start, and the first leading edge drives its MSB.
  - If the TX buffer is full, it moves into the shift register and `tx_ready` returns to 1 the next cycle.
  - Otherwise `TX_IDLE` is loaded and `tx_underrun` pulses.
- **TX handshake**
  - A transfer occurs when `tx_valid && tx_ready`; the buffer becomes full and `tx_ready` drops next cycle.
  - A buffer load and a consume in the same cycle are not possible, because the buffer is empty only when `tx_ready`=1.
- **RX completion** (`DATA_W`th sample)
  - `bit_cnt` wraps to 0 and the word is offered to the RX storage.
  - Without FIFO: one holding register. If `rx_valid && !rx_ready` at completion, the new word is dropped and `rx_overrun` pulses.
  - A completion coincident with `rx_ready`=1 is accepted with no overrun.
- **`ss_n` rising mid-word**
  - Discard the partial RX word and clear `bit_cnt`; drive `busy`=0 and `miso_oe`=0.
  - A TX word already in the shift register counts as consumed and is not re-sent.
- **`sclk` edges while `ss_n` is high**: ignored.
- **`rst` asserted mid-frame**: immediate return to reset values; the next frame requires a fresh `ss_n` falling edge.

Optional Feature:
- `SPI_SLAVE_RX_FIFO_EN` defined:
  - RX storage is a FIFO of `RX_FIFO_DEPTH` entries, first-word-fall-through.
  - `rx_valid` = not empty; a pop happens on `rx_valid && rx_ready`.
  - `rx_overrun` pulses only when a word completes while the FIFO is full and no pop occurs that cycle.
  - Pointers wrap modulo depth.
- Undefined: single holding register, as described above.

Test Plan:
1. Reset then idle → outputs at reset values; `tx_ready`=1.
2. Mode 0, `tx_data`=8'hA5 preloaded, master sends 8'h3C → master receives 8'hA5; `rx_data`=8'h3C with `rx_valid`=1; `tx_underrun` never pulses.
3. Mode 3, two-word frame (8'h12, 8'h34), only one TX word 8'hC3 → master receives 8'hC3 then 8'hFF; `tx_underrun` pulses once.
4. Mode 1 frame, `ss_n` deasserted after 5 bits → no `rx_valid`; `miso_oe`=0; next full frame of 8'h81 received correctly.
5. `rx_ready` held 0, three words 8'h01/8'h02/8'h03 → without FIFO: `rx_data`=8'h01 and two `rx_overrun` pulses. With FIFO (depth 4): all three are held and popped in order with no overrun.
6. Word completion coincident with `rx_ready`=1 on a pending word → both words delivered; no `rx_overrun`.
